// File: rtl/mux2_sel_pkg.sv
// Shared types and constants for the 2:1 mux select controller.
// Optional feature macro: MUX_SEL_BLANK_EN (one-cycle blanking on select change).
package mux2_sel_pkg;

  localparam int CNT_W = 8;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    GNT_A,
    GNT_B,
    BLANK
  } state_t;

endpackage

// File: rtl/mux2_sel_ctrl_dwell_counter.sv
// Saturating dwell counter for the mux select controller.
// Flags the last cycle of a grant period (count == limit-1).
module dwell_counter
  import mux2_sel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX = '1;

  // Count grant cycles; clear on grant entry, hold at the top value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != MAX) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == limit - 1'b1);

endmodule

// File: rtl/mux2_sel_ctrl.sv
// Round-robin select controller for the 2:1 gate-level mux.
// Define MUX_SEL_BLANK_EN to insert a 1-cycle BLANK on every select change.
module mux2_sel_ctrl
  import mux2_sel_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic s,
  output logic valid,
  output logic gnt_a,
  output logic gnt_b
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DWELL);

  state_t           state;
  state_t           state_nx;
  logic             s_nx;
  logic             valid_nx;
  logic             last_ch;
  logic             last_nx;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             dwell_end;
  logic             want;
  logic             tgt;
  logic             go_idle;

  assign cnt_en    = (state == GNT_A) || (state == GNT_B);
  assign dwell_end = cnt_last || (cnt > LIMIT - 1'b1);

  dwell_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (LIMIT),
    .count (cnt),
    .last  (cnt_last)
  );

  // Registered state, select, valid and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s       <= SEL_A;
      valid   <= 1'b0;
      last_ch <= SEL_B;
    end else begin
      state   <= state_nx;
      s       <= s_nx;
      valid   <= valid_nx;
      last_ch <= last_nx;
    end
  end

  // Pick the next owner, then decide how the select reaches it.
  always_comb begin
    state_nx = state;
    s_nx     = s;
    valid_nx = valid;
    last_nx  = last_ch;
    cnt_clr  = 1'b0;
    want     = 1'b0;
    tgt      = SEL_A;
    go_idle  = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_a && req_b) begin
          want = 1'b1;
          tgt  = ~last_ch;
        end else if (req_a) begin
          want = 1'b1;
          tgt  = SEL_A;
        end else if (req_b) begin
          want = 1'b1;
          tgt  = SEL_B;
        end
      end
      GNT_A: begin
        if (!req_a || dwell_end) begin
          if (req_b) begin
            want = 1'b1;
            tgt  = SEL_B;
          end else if (req_a) begin
            want = 1'b1;
            tgt  = SEL_A;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      GNT_B: begin
        if (!req_b || dwell_end) begin
          if (req_a) begin
            want = 1'b1;
            tgt  = SEL_A;
          end else if (req_b) begin
            want = 1'b1;
            tgt  = SEL_B;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      BLANK: begin
        // select already carries the chosen channel
        want = 1'b1;
        tgt  = s;
      end
    endcase

    if (go_idle) begin
      state_nx = IDLE;
      valid_nx = 1'b0;
      cnt_clr  = 1'b1;
    end else if (want) begin
`ifdef MUX_SEL_BLANK_EN
      if (state != BLANK && tgt != s) begin
        state_nx = BLANK;
        s_nx     = tgt;
        valid_nx = 1'b0;
        cnt_clr  = 1'b1;
      end else begin
        state_nx = tgt ? GNT_B : GNT_A;
        s_nx     = tgt;
        valid_nx = 1'b1;
        last_nx  = tgt;
        cnt_clr  = 1'b1;
      end
`else
      state_nx = tgt ? GNT_B : GNT_A;
      s_nx     = tgt;
      valid_nx = 1'b1;
      last_nx  = tgt;
      cnt_clr  = 1'b1;
`endif
    end
  end

  assign gnt_a = valid & ~s;
  assign gnt_b = valid & s;

endmodule

// File: tb/tb_mux2_sel_ctrl.sv
// Self-checking bench for mux2_sel_ctrl.
// Honors MUX_SEL_BLANK_EN the same way as the design build.
module tb_mux2_sel_ctrl;

  localparam int DWELL = 4;
`ifdef MUX_SEL_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic s, valid, gnt_a, gnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux2_sel_ctrl #(.DWELL(DWELL)) dut (
    .clk   (clk),
    .rst   (rst),
    .req_a (req_a),
    .req_b (req_b),
    .s     (s),
    .valid (valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 0=none 1=A 2=B 3=blanking; held = cycles finished in period.
  int   m_own;
  int   m_held;
  int   m_last;
  logic m_s;

  always @(posedge clk or posedge rst) begin : model
    int   tgt;
    bit   cont;
    logic mine, other, nsel;
    if (rst) begin
      m_own  = 0;
      m_held = 0;
      m_last = 2;
      m_s    = 1'b0;
    end else begin
      tgt  = 0;
      cont = 1'b0;
      case (m_own)
        0: begin
          if (req_a && req_b) tgt = (m_last == 2) ? 1 : 2;
          else if (req_a) tgt = 1;
          else if (req_b) tgt = 2;
        end
        1, 2: begin
          mine  = (m_own == 1) ? req_a : req_b;
          other = (m_own == 1) ? req_b : req_a;
          if (mine && (m_held + 1 < DWELL)) cont = 1'b1;
          else if (other) tgt = 3 - m_own;
          else if (mine) tgt = m_own;
        end
        default: tgt = m_s ? 2 : 1;
      endcase
      if (cont) begin
        m_held++;
      end else if (tgt == 0) begin
        m_own = 0;
      end else begin
        nsel = (tgt == 2);
        if (BLANK_EN && m_own != 3 && nsel != m_s) begin
          m_own = 3;
          m_s   = nsel;
        end else begin
          m_own  = tgt;
          m_s    = nsel;
          m_held = 0;
          m_last = tgt;
        end
      end
    end
  end

  // Compare every settled cycle against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_s", s, m_s);
      chk("m_valid", valid, (m_own == 1 || m_own == 2));
      chk("m_gnt_a", gnt_a, (m_own == 1));
      chk("m_gnt_b", gnt_b, (m_own == 2));
    end
  end

  task automatic do_reset();
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [11:0] exp_s;
  logic [11:0] exp_v;

  initial begin
    // reset with both requests high
    rst   = 1'b1;
    req_a = 1'b1;
    req_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_s", s, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_gnt_a", gnt_a, 1'b0);
    chk("rst_gnt_b", gnt_b, 1'b0);
    rst = 1'b0;

    // contention sequence from the first grant
    if (BLANK_EN) begin
      exp_s = 12'b0000_1111_1000;
      exp_v = 12'b1111_0111_1011;
    end else begin
      exp_s = 12'b0000_1111_0000;
      exp_v = 12'b1111_1111_1111;
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) chk("first_tie_gnt_a", gnt_a, 1'b1);
      chk("cont_s", s, exp_s[11-i]);
      chk("cont_valid", valid, exp_v[11-i]);
    end

    // single requester B, restarts without gaps
    do_reset();
    req_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("single_s", s, 1'b1);
      chk("single_valid", valid, (i == 0) ? !BLANK_EN : 1'b1);
    end
    req_b = 1'b0;

    // early release of A with B waiting
    do_reset();
    req_a = 1'b1;
    repeat (2) @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b1;
    @(negedge clk);
    chk("early_s", s, 1'b1);
    chk("early_valid", valid, !BLANK_EN);
    @(negedge clk);
    chk("early_gnt_b", gnt_b, 1'b1);

    // early release with nobody waiting
    do_reset();
    req_a = 1'b1;
    repeat (2) @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    chk("drop_valid", valid, 1'b0);
    chk("drop_s", s, 1'b0);
    repeat (2) @(negedge clk);
    chk("idle_s_hold", s, 1'b0);

    // asynchronous reset during the second cycle of a B grant
    do_reset();
    req_b = 1'b1;
    @(negedge clk);
    if (BLANK_EN) @(negedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_gnt_b", gnt_b, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_s", s, 1'b0);
    chk("async_valid", valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s", s, 1'b1);
    chk("post_rst_valid", valid, !BLANK_EN);

    req_b = 1'b0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
